// File: rtl/mov_wide_exec_if.sv
// mov_wide_exec_if: decode-side and writeback-side valid/ready bundle for mov_wide_exec
interface mov_wide_exec_if;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic        in_sf;
    logic [1:0]  in_hw;
    logic [15:0] in_imm16;
    logic [4:0]  in_rd;
    logic [63:0] in_rd_val;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_rd;
    logic [63:0] out_result;
    logic        out_illegal;

    modport master (
        output in_valid, in_op, in_sf, in_hw, in_imm16, in_rd, in_rd_val, out_ready,
        input  in_ready, out_valid, out_rd, out_result, out_illegal
    );

    modport slave (
        input  in_valid, in_op, in_sf, in_hw, in_imm16, in_rd, in_rd_val, out_ready,
        output in_ready, out_valid, out_rd, out_result, out_illegal
    );
endinterface

// File: rtl/mov_wide_exec.sv
// mov_wide_exec: two-stage MOVZ/MOVK/MOVN execute unit; define MOVK_FWD_EN to forward stage-2 results into a dependent MOVK
module mov_wide_exec #(
    parameter logic [4:0] XZR_IDX = 5'd31
) (
    input logic            clk,
    input logic            reset_n,
    mov_wide_exec_if.slave bus_io
);
    localparam logic [1:0] OP_MOVK = 2'b01;
    localparam logic [1:0] OP_MOVN = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;
`ifdef MOVK_FWD_EN
    localparam logic FWD_EN = 1'b1;
`else
    localparam logic FWD_EN = 1'b0;
`endif

    logic        s1_valid_q;
    logic [1:0]  s1_op_q;
    logic        s1_sf_q;
    logic        s1_ill_q;
    logic [4:0]  s1_rd_q;
    logic [63:0] s1_val_q;
    logic [63:0] s1_keep_q;
    logic [63:0] s1_rd_val_q;
    logic        s2_valid_q;
    logic        s2_ill_q;
    logic [4:0]  s2_rd_q;
    logic [63:0] s2_result_q;

    logic        adv1;
    logic        adv2;
    logic [5:0]  shamt;
    logic        s1_ill_d;
    logic [63:0] s1_val_d;
    logic [63:0] s1_keep_d;
    logic        fwd_hit;
    logic [63:0] old_val;
    logic [63:0] s2_result_d;

    // Stage 2 may load when empty or draining; stage 1 when empty or moving into stage 2
    assign adv2           = !s2_valid_q || bus_io.out_ready;
    assign adv1           = !s1_valid_q || adv2;
    assign bus_io.in_ready = adv1;

    assign shamt     = {bus_io.in_hw, 4'b0000};
    assign s1_val_d  = {48'h0, bus_io.in_imm16} << shamt;
    assign s1_keep_d = ~({48'h0, 16'hFFFF} << shamt);
    assign s1_ill_d  = (bus_io.in_op == OP_RSVD) || (!bus_io.in_sf && bus_io.in_hw[1]);

    // Stage-2 value: choose old Rd (forwarded or latched), apply the op, clip 32-bit forms, squash illegal ops
    always_comb begin
        fwd_hit     = FWD_EN && (s1_op_q == OP_MOVK) && s2_valid_q && (s2_rd_q == s1_rd_q) && (s1_rd_q != XZR_IDX);
        old_val     = fwd_hit ? s2_result_q : s1_rd_val_q;
        s2_result_d = (s1_op_q == OP_MOVN) ? ~s1_val_q :
                      (s1_op_q == OP_MOVK) ? ((old_val & s1_keep_q) | s1_val_q) : s1_val_q;
        if (!s1_sf_q)
            s2_result_d[63:32] = 32'h0;
        if (s1_ill_q)
            s2_result_d = 64'h0;
    end

    // Stage 1: latch the shaped operands of an accepted op
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q  <= 1'b0;
            s1_op_q     <= 2'b00;
            s1_sf_q     <= 1'b0;
            s1_ill_q    <= 1'b0;
            s1_rd_q     <= 5'd0;
            s1_val_q    <= 64'h0;
            s1_keep_q   <= 64'h0;
            s1_rd_val_q <= 64'h0;
        end else begin
            if (adv1)
                s1_valid_q <= bus_io.in_valid;
            if (adv1 && bus_io.in_valid) begin
                s1_op_q     <= bus_io.in_op;
                s1_sf_q     <= bus_io.in_sf;
                s1_ill_q    <= s1_ill_d;
                s1_rd_q     <= bus_io.in_rd;
                s1_val_q    <= s1_val_d;
                s1_keep_q   <= s1_keep_d;
                s1_rd_val_q <= bus_io.in_rd_val;
            end
        end
    end

    // Stage 2: hold the result steady until writeback takes it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid_q  <= 1'b0;
            s2_ill_q    <= 1'b0;
            s2_rd_q     <= 5'd0;
            s2_result_q <= 64'h0;
        end else begin
            if (adv2)
                s2_valid_q <= s1_valid_q;
            if (adv2 && s1_valid_q) begin
                s2_ill_q    <= s1_ill_q;
                s2_rd_q     <= s1_rd_q;
                s2_result_q <= s2_result_d;
            end
        end
    end

    assign bus_io.out_valid   = s2_valid_q;
    assign bus_io.out_rd      = s2_rd_q;
    assign bus_io.out_result  = s2_result_q;
    assign bus_io.out_illegal = s2_ill_q;
endmodule
